// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, field positions and widths for the register sequencer
package seq_pkg;

    localparam int DATA_W = 8;

    // Instruction word field positions
    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 5;
    localparam int DST_BIT = 4;
    localparam int RSEL_HI = 3;
    localparam int RSEL_LO = 2;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MOV = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

endpackage

// File: rtl/reg_sequencer_alu8.sv
// rtl/reg_sequencer_alu8.sv - combinational 8-bit ALU used by the register sequencer
//
// Ports:
//   opcode    in  3  instruction opcode (seq_pkg::opcode_t encoding)
//   a, b      in  8  operands (register-file read0 / read1)
//   imm       in  4  immediate for LDI
//   result    out 8  ALU result, modulo 256
//   carry_out out 1  carry for ADD, borrow for SUB, 0 otherwise
//   zero_out  out 1  result == 0
module alu8
    import seq_pkg::*;
(
    input  logic [2:0]          opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [3:0]          imm,
    output logic [DATA_W-1:0]   result,
    output logic                carry_out,
    output logic                zero_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        // Bit 8 of the extended difference is the unsigned borrow (a < b).
        diff      = {1'b0, a} - {1'b0, b};
        result    = '0;
        carry_out = 1'b0;
        case (opcode)
            OP_LDI: result = {4'b0000, imm};
            OP_ADD: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_SUB: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = a;
            default: result = '0;
        endcase
    end

    assign zero_out = (result == '0);

endmodule

// File: rtl/reg_sequencer.sv
// rtl/reg_sequencer.sv - four-state instruction sequencer in front of a two-entry register file
//
// Ports:
//   sysclk, rst_n            clock, asynchronous active-low reset
//   instr, instr_valid       instruction in, accepted when instr_ready is high
//   instr_ready              high only in IDLE
//   read0, read1             register-file operands A / B, sampled in EXEC
//   rsel                     read selects, loaded on accept and held
//   wsel, rw, w              write destination, write strobe, write data
//   busy, done               not-IDLE indicator, one-cycle completion pulse in WRITE
//   carry, zero, retired     flags and completed-instruction counter
module reg_sequencer
    import seq_pkg::*;
(
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [7:0]  instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  read0,
    input  logic [7:0]  read1,
    output logic [1:0]  rsel,
    output logic        wsel,
    output logic        rw,
    output logic [7:0]  w,
    output logic        busy,
    output logic        done,
    output logic        carry,
    output logic        zero,
    output logic [7:0]  retired
);

    state_t             state_q, state_d;
    logic [7:0]         ir_q;
    logic [1:0]         rsel_q;
    logic               wsel_q;
    logic [DATA_W-1:0]  w_q;
    logic               carry_q, zero_q;
    logic [7:0]         retired_q;

    logic [2:0]         opc;
    logic               is_nop;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry, alu_zero;

    assign opc    = ir_q[OPC_HI:OPC_LO];
    assign is_nop = (opc == OP_NOP);

    alu8 u_alu (
        .opcode    (opc),
        .a         (read0),
        .b         (read1),
        .imm       (ir_q[IMM_HI:IMM_LO]),
        .result    (alu_result),
        .carry_out (alu_carry),
        .zero_out  (alu_zero)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are decoded from the state register, so an asynchronous reset
    // drops rw/done immediately without waiting for an edge.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        rw          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                done    = 1'b1;
                rw      = !is_nop;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= '0;
            rsel_q    <= '0;
            wsel_q    <= 1'b0;
            w_q       <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            // Read selects are loaded on accept so they are valid for the whole READ cycle.
            if (state_q == ST_IDLE && instr_valid) begin
                ir_q   <= instr;
                rsel_q <= instr[RSEL_HI:RSEL_LO];
            end
            // NOP leaves flags, write data and write select untouched.
            if (state_q == ST_EXEC && !is_nop) begin
                w_q     <= alu_result;
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
                wsel_q  <= ir_q[DST_BIT];
            end
            if (state_q == ST_WRITE) begin
                retired_q <= retired_q + 8'd1;
            end
        end
    end

    assign rsel    = rsel_q;
    assign wsel    = wsel_q;
    assign w       = w_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// tb/tb_reg_sequencer.sv - self-checking bench for reg_sequencer
module tb_reg_sequencer;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  read0, read1;
    logic [1:0]  rsel;
    logic        wsel, rw, busy, done, carry, zero;
    logic [7:0]  w, retired;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    logic [7:0] exp_w, exp_retired;
    logic [1:0] exp_rsel;
    logic       exp_wsel, exp_carry, exp_zero;

    reg_sequencer dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .read0       (read0),
        .read1       (read1),
        .rsel        (rsel),
        .wsel        (wsel),
        .rw          (rw),
        .w           (w),
        .busy        (busy),
        .done        (done),
        .carry       (carry),
        .zero        (zero),
        .retired     (retired)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_w       = 8'h00;
        exp_wsel    = 1'b0;
        exp_rsel    = 2'b00;
        exp_carry   = 1'b0;
        exp_zero    = 1'b0;
        exp_retired = 8'h00;
    endtask

    task automatic check_reset_vals();
        chk("rst_ready",   instr_ready, 1);
        chk("rst_busy",    busy,        0);
        chk("rst_done",    done,        0);
        chk("rst_rw",      rw,          0);
        chk("rst_w",       w,           8'h00);
        chk("rst_wsel",    wsel,        0);
        chk("rst_rsel",    rsel,        2'b00);
        chk("rst_carry",   carry,       0);
        chk("rst_zero",    zero,        0);
        chk("rst_retired", retired,     8'h00);
    endtask

    // Apply the spec's arithmetic rules directly on integers.
    task automatic model_exec(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
        int op, ia, ib, r;
        bit cy;
        op = int'(ins) / 32;
        ia = int'(a);
        ib = int'(b);
        cy = 1'b0;
        r  = 0;
        case (op)
            1: r = int'(ins) % 16;
            2: begin r = (ia + ib) % 256; cy = (ia + ib) > 255; end
            3: begin r = (ia - ib + 256) % 256; cy = ia < ib; end
            4: r = ia & ib;
            5: r = ia | ib;
            6: r = ia ^ ib;
            7: r = ia;
            default: r = 0;
        endcase
        exp_rsel = 2'((int'(ins) / 4) % 4);
        if (op != 0) begin
            exp_w     = 8'(r);
            exp_wsel  = ((int'(ins) / 16) % 2) == 1;
            exp_carry = cy;
            exp_zero  = (r == 0);
        end
    endtask

    // One full instruction; with junk set, instr_valid stays high with random words while busy.
    task automatic issue(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b, input bit junk);
        logic [7:0] prev_w;
        bit writes;
        @(negedge sysclk);
        chk("idle_ready",   instr_ready, 1);
        chk("idle_busy",    busy,        0);
        chk("idle_retired", retired,     exp_retired);
        prev_w      = exp_w;
        instr       = ins;
        instr_valid = 1'b1;
        read0       = a;
        read1       = b;
        writes      = (ins / 32) != 0;
        model_exec(ins, a, b);
        @(posedge sysclk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge sysclk);
            instr_valid = junk;
            if (junk) instr = 8'($urandom);
            chk("busy",  busy,        1);
            chk("ready", instr_ready, 0);
            chk("rsel",  rsel,        exp_rsel);
            if (c < 3) begin
                chk("rw_early",   rw,   0);
                chk("done_early", done, 0);
                chk("w_hold",     w,    prev_w);
            end else begin
                chk("rw",    rw,    writes);
                chk("done",  done,  1);
                chk("w",     w,     exp_w);
                chk("wsel",  wsel,  exp_wsel);
                chk("carry", carry, exp_carry);
                chk("zero",  zero,  exp_zero);
            end
        end
        exp_retired = exp_retired + 8'd1;
    endtask

    // Accept an instruction, then reset in the middle of its EXEC cycle.
    task automatic issue_abort(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
        @(negedge sysclk);
        instr       = ins;
        instr_valid = 1'b1;
        read0       = a;
        read1       = b;
        @(posedge sysclk);
        @(negedge sysclk);
        instr_valid = 1'b0;
        chk("abort_busy", busy, 1);
        @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            chk("abort_rw",      rw,      0);
            chk("abort_retired", retired, 8'h00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("post_rw", rw, 0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = 8'h00;
        instr_valid = 1'b0;
        read0       = 8'h00;
        read1       = 8'h00;
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        check_reset_vals();
        @(negedge sysclk);
        rst_n = 1'b1;

        issue_abort(8'h5C, 8'hF0, 8'h20);

        issue(8'h2A, 8'h33, 8'h44, 1'b0);
        chk("ldi_w", w, 8'h0A);
        issue(8'h5C, 8'hF0, 8'h20, 1'b0);
        chk("add_w", w, 8'h10);
        issue(8'h6C, 8'h05, 8'h05, 1'b0);
        issue(8'h6C, 8'h03, 8'h05, 1'b0);
        chk("sub_w", w, 8'hFE);
        issue(8'h00, 8'h12, 8'h34, 1'b1);

        for (int i = 0; i < 80; i++) begin
            issue(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        @(negedge sysclk);
        instr_valid = 1'b0;

        @(negedge sysclk);
        rst_n = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            issue(8'h00, 8'($urandom), 8'($urandom), 1'b0);
        end
        @(negedge sysclk);
        chk("wrap_retired", retired, 8'h00);
        chk("wrap_carry",   carry,   0);
        chk("wrap_zero",    zero,    0);

        issue_abort(8'h5C, 8'h01, 8'h02);
        chk("final_retired", retired, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
